mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported 512 KB byte memory between two requesters: instruction fetch (IF)
//  and the data load/store path (D). One transaction is outstanding at a time.
//  Runs it through a grant / fixed-latency / response sequence.
//  Sits between the fetch/control logic and the memory in tinker_core.
// PARAMETERS
//  ADDR_W      32  byte address width
//  DATA_W      64  data word width; IF returns the low 32 bits
//  MEM_LAT     2   cycles from the mem_en cycle to valid mem_rdata; legal range >=1
//  STARVE_MAX  4   consecutive IF losses before IF gets forced priority; legal range >=1
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  reset      in   1       asynchronous, active-high reset
//  if_req     in   1       fetch request; hold with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch byte address
//  if_gnt     out  1       1-cycle pulse: fetch accepted
//  if_rvalid  out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  32      fetched instruction, = captured mem_rdata[31:0]
//  d_req      in   1       data request; hold with d_we, d_addr, d_wdata until d_gnt
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data byte address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       1-cycle pulse: data request accepted
//  d_rvalid   out  1       1-cycle pulse: load data valid, or store complete
//  d_rdata    out  DATA_W  load data; unchanged on a store completion
//  mem_en     out  1       memory access strobe, exactly 1 cycle per transaction
//  mem_we     out  1       store strobe; high only together with mem_en
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  DATA_W  latched store data
//  mem_rdata  in   DATA_W  memory read data (little-endian), valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  Reset (async)
//   - State goes to IDLE; latency and starve counters go to 0.
//   - All outputs go to 0, including if_rdata and d_rdata.
//   - Reset mid-transaction: the in-flight response is discarded and no rvalid is ever emitted.
//     A store that already pulsed mem_en is not rolled back.
//  FSM states: IDLE, ACCESS, WAIT, RESP.
//   - IDLE: arbitrate. Any req -> ACCESS; no req -> stay in IDLE.
//   - ACCESS: lasts 1 cycle. gnt to the winner, mem_en=1, mem_we=latched d_we for D (0 for IF).
//     Always goes to WAIT.
//   - WAIT: lasts MEM_LAT cycles, counted by the latency counter. On the last WAIT edge,
//     mem_rdata is captured into the winner's rdata register. Then -> RESP.
//   - RESP: lasts 1 cycle. Winner's rvalid=1. Arbitrates again in the same cycle:
//     any req -> ACCESS, else -> IDLE. Back-to-back transactions take MEM_LAT+2 cycles each.
//  Latency
//   - req high in IDLE cycle 0 -> gnt and mem_en in cycle 1 -> rvalid in cycle MEM_LAT+2.
//   - Addr, we and wdata are sampled on the edge that enters ACCESS. Requester inputs are
//     don't-care after gnt.
//  Arbitration
//   - D wins by default when both requesters ask.
//   - IF wins if starve_cnt == STARVE_MAX.
//   - starve_cnt increments (saturating at STARVE_MAX) on each decision where IF requested
//     and lost.
//   - starve_cnt clears when IF is granted, or when if_req is low at a decision.
//   - A req dropped before gnt is a withdrawal and is legal; nothing is issued for it.
//  Other rules
//   - Only the winner's gnt and rvalid pulse; the loser's rdata register holds its value.
//   - Addresses pass through unmodified; there is no alignment check.
//     mem_addr + 7 wrap is the memory's concern.
// STRUCTURE
//  - Package tinker_mem_pkg holds:
//    - typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
//    - typedef enum logic {REQ_IF, REQ_D} req_id_t;
//    - localparams ADDR_W and DATA_W;
//    - function arb_pick(if_req, d_req, starve_sat) returning req_id_t.
//  - No sub-module. The FSM, latency counter, starve counter and capture registers are inline.
// TESTING
//  1. Reset, then if_req=1, if_addr=0x2000, mem returns 0x...DEADBEEF -> if_gnt in cycle 1;
//     mem_en and mem_addr=0x2000 in cycle 1; if_rvalid in cycle 4 (MEM_LAT=2) with
//     if_rdata=0xDEADBEEF.
//  2. Store: d_req=1, d_we=1, d_addr=0x10000, d_wdata=0x1122334455667788 -> mem_en and
//     mem_we high together for 1 cycle with those values; d_rvalid in cycle 4; d_rdata
//     unchanged.
//  3. if_req and d_req both held continuously (STARVE_MAX=4) -> grant order D,D,D,D,IF,D,...;
//     grants spaced MEM_LAT+2=4 cycles apart (RESP->ACCESS, no IDLE cycle).
//  4. Assert reset asynchronously mid-clock during WAIT of a load -> all outputs 0 at once;
//     no d_rvalid afterwards; the next request after deassertion completes normally.
//  5. d_req pulsed 1 cycle during WAIT and dropped before RESP -> no second gnt or mem_en;
//     FSM returns to IDLE.
//  6. MEM_LAT=1 build: load to 0x80 -> d_rvalid in cycle 3; the captured value equals
//     mem_rdata at the single WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, widths and the arbitration rule for the tinker_core memory port arbiter.
package tinker_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
  typedef enum logic {REQ_IF, REQ_D} req_id_t;

  // Data path wins ties unless instruction fetch has been starved long enough.
  // Only meaningful when at least one request is high.
  function automatic req_id_t arb_pick(input logic if_req, input logic d_req,
                                       input logic starve_sat);
    if (if_req && (starve_sat || !d_req)) return REQ_IF;
    return REQ_D;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester handshakes and the memory bus of the arbiter.
// slave  : the arbiter's view (takes requests, drives the memory strobes)
// master : the surrounding logic's view (requesters plus memory read data)
interface mem_port_arbiter_if
  import tinker_mem_pkg::*;
  ();

  // instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  // data load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between instruction fetch and the data path.
// One transaction at a time: IDLE/RESP arbitrate, ACCESS strobes the memory for one
// cycle, WAIT covers the fixed memory latency, RESP pulses the winner's rvalid.
module mem_port_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  // Latency counter runs 0..MEM_LAT-1; starve counter runs 0..STARVE_MAX.
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [STV_W-1:0]  r_starve_cnt;
  req_id_t           r_winner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [31:0]       r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_decide;
  logic              w_any_req;
  logic              w_start;
  logic              w_starve_sat;
  logic              w_lat_done;
  req_id_t           w_pick;

  assign w_decide     = (r_state == IDLE) || (r_state == RESP);
  assign w_any_req    = bus.if_req || bus.d_req;
  assign w_start      = w_decide && w_any_req;
  assign w_starve_sat = (r_starve_cnt == STV_W'(STARVE_MAX));
  assign w_lat_done   = (r_lat_cnt == LAT_W'(MEM_LAT - 1));
  assign w_pick       = arb_pick(bus.if_req, bus.d_req, w_starve_sat);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the always blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps every path assigned, so no latch
  // is inferred when a case arm leaves the target untouched.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = ACCESS;
      ACCESS:  w_next_state = WAIT;
      WAIT:    if (w_lat_done) w_next_state = RESP;
      RESP:    w_next_state = w_any_req ? ACCESS : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake and memory strobes, decoded from the state and the latched winner.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    case (r_state)
      ACCESS: begin
        bus.mem_en = 1'b1;
        bus.mem_we = (r_winner == REQ_D) && r_we;
        bus.if_gnt = (r_winner == REQ_IF);
        bus.d_gnt  = (r_winner == REQ_D);
      end
      RESP: begin
        bus.if_rvalid = (r_winner == REQ_IF);
        bus.d_rvalid  = (r_winner == REQ_D);
      end
      default: ;
    endcase
  end

  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;

  // Latency counter: counts WAIT cycles, parked at zero elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_lat_cnt <= '0;
    else if (r_state != WAIT)  r_lat_cnt <= '0;
    else if (w_lat_done)       r_lat_cnt <= '0;
    else                       r_lat_cnt <= r_lat_cnt + LAT_W'(1);
  end

  // Starve counter: counts consecutive decisions where fetch asked and lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_decide) begin
      if (bus.if_req && (w_pick == REQ_D)) begin
        if (!w_starve_sat) r_starve_cnt <= r_starve_cnt + STV_W'(1);
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  // Request latch: winner, address, direction and store data on entry to ACCESS.
  // Store data is only taken from the data path; a fetch leaves it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_winner <= REQ_IF;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_start) begin
      r_winner <= w_pick;
      if (w_pick == REQ_IF) begin
        r_addr <= bus.if_addr;
        r_we   <= 1'b0;
      end else begin
        r_addr  <= bus.d_addr;
        r_we    <= bus.d_we;
        r_wdata <= bus.d_wdata;
      end
    end
  end

  // Response capture on the last WAIT edge; stores and the losing side keep their data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if ((r_state == WAIT) && w_lat_done) begin
      if (r_winner == REQ_IF) r_if_rdata <= bus.mem_rdata[31:0];
      else if (!r_we)         r_d_rdata  <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for single
// transactions, then hand-written sequences for starvation, async reset and MEM_LAT=1.
module tb_mem_port_arbiter;
  import tinker_mem_pkg::*;

  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Memory contents seen by the bench: address-dependent, 0x2000 reads ...DEADBEEF.
  function automatic logic [63:0] rd_fn(input logic [31:0] a);
    return {32'hA5A5_0000 | {16'h0, a[15:0]}, 32'hDEADBEEF ^ (a - 32'h2000)};
  endfunction

  // Memory models: data valid exactly MEM_LAT cycles after mem_en, junk otherwise.
  logic        v_a0 = 1'b0, v_a1 = 1'b0, v_b0 = 1'b0;
  logic [63:0] d_a0 = '0, d_a1 = '0, d_b0 = '0;
  always @(posedge clk) begin
    v_a0 <= bus_a.mem_en;
    d_a0 <= rd_fn(bus_a.mem_addr);
    v_a1 <= v_a0;
    d_a1 <= d_a0;
    v_b0 <= bus_b.mem_en;
    d_b0 <= rd_fn(bus_b.mem_addr);
  end
  assign bus_a.mem_rdata = v_a1 ? d_a1 : JUNK;
  assign bus_b.mem_rdata = v_b0 ? d_b0 : JUNK;

  // Control outputs packed as {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid}.
  logic [5:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.if_gnt, bus_a.d_gnt, bus_a.mem_en, bus_a.mem_we,
                  bus_a.if_rvalid, bus_a.d_rvalid};
  assign ctl_b = {bus_b.if_gnt, bus_b.d_gnt, bus_b.mem_en, bus_b.mem_we,
                  bus_b.if_rvalid, bus_b.d_rvalid};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic [5:0]  exp_ctl;
    logic [31:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [31:0] exp_if_rdata;
    logic [63:0] exp_d_rdata;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dw, input logic [31:0] da, input logic [63:0] dd,
                              input logic [5:0] ec, input logic [31:0] ea,
                              input logic [63:0] ew, input logic [31:0] eir,
                              input logic [63:0] edr);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.exp_ctl = ec; v.exp_addr = ea; v.exp_wdata = ew;
    v.exp_if_rdata = eir; v.exp_d_rdata = edr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.d_req = 1'b0;
    bus_a.d_we = 1'b0; bus_a.d_addr = '0; bus_a.d_wdata = '0;
    bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.d_req = 1'b0;
    bus_b.d_we = 1'b0; bus_b.d_addr = '0; bus_b.d_wdata = '0;
  endtask

  vec_t vecs[17];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd_4000, rd_0040, rd_0080;
    int          g_cyc[$];
    logic        g_isif[$];
    int          rv_cyc;
    int          rv_seen;
    int          gnt_cyc;
    logic [63:0] rv_data;

    rd_4000 = 64'hA5A54000_DEAD9EEF;
    rd_0040 = 64'hA5A50040_21525EAF;
    rd_0080 = 64'hA5A50080_21525E6F;

    // fetch 0x2000, store 0x10000, then a load with a stray store pulse during WAIT
    vecs[0]  = mk(1, 32'h2000, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h0, 64'h0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 6'b101000, 32'h2000, 0, 32'h0, 64'h0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h0, 64'h0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'h0, 64'h0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 6'b000010, 0, 0, 32'hDEADBEEF, 64'h0);
    vecs[5]  = mk(0, 0, 1, 1, 32'h10000, 64'h1122334455667788, 6'b000000, 0, 0,
                  32'hDEADBEEF, 64'h0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 6'b011100, 32'h10000, 64'h1122334455667788,
                  32'hDEADBEEF, 64'h0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'hDEADBEEF, 64'h0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'hDEADBEEF, 64'h0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 32'hDEADBEEF, 64'h0);
    vecs[10] = mk(0, 0, 1, 0, 32'h4000, 0, 6'b000000, 0, 0, 32'hDEADBEEF, 64'h0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 6'b011000, 32'h4000, 0, 32'hDEADBEEF, 64'h0);
    vecs[12] = mk(0, 0, 1, 1, 32'h5000, 64'hFFFF_FFFF_FFFF_FFFF, 6'b000000, 0, 0,
                  32'hDEADBEEF, 64'h0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'hDEADBEEF, 64'h0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 6'b000001, 0, 0, 32'hDEADBEEF, rd_4000);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'hDEADBEEF, rd_4000);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 32'hDEADBEEF, rd_4000);

    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();

    // table: one row per cycle, inputs applied then outputs of that cycle compared
    for (int i = 0; i < 17; i++) begin
      bus_a.if_req  = vecs[i].if_req;
      bus_a.if_addr = vecs[i].if_addr;
      bus_a.d_req   = vecs[i].d_req;
      bus_a.d_we    = vecs[i].d_we;
      bus_a.d_addr  = vecs[i].d_addr;
      bus_a.d_wdata = vecs[i].d_wdata;
      check($sformatf("row%0d_ctl", i), 64'(ctl_a), 64'(vecs[i].exp_ctl));
      check($sformatf("row%0d_if_rdata", i), 64'(bus_a.if_rdata), 64'(vecs[i].exp_if_rdata));
      check($sformatf("row%0d_d_rdata", i), bus_a.d_rdata, vecs[i].exp_d_rdata);
      if (vecs[i].exp_ctl[3])
        check($sformatf("row%0d_mem_addr", i), 64'(bus_a.mem_addr), 64'(vecs[i].exp_addr));
      if (vecs[i].exp_ctl[2])
        check($sformatf("row%0d_mem_wdata", i), bus_a.mem_wdata, vecs[i].exp_wdata);
      tick();
    end

    // starvation: both requesters held, expect D,D,D,D,IF repeating, 4 cycles apart
    idle_inputs();
    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h100;
    bus_a.d_req  = 1'b1; bus_a.d_addr  = 32'h200; bus_a.d_we = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus_a.if_gnt && bus_a.d_gnt) check("dual_gnt", 64'(c), 64'hFFFF);
      if (bus_a.if_gnt || bus_a.d_gnt) begin
        g_cyc.push_back(c);
        g_isif.push_back(bus_a.if_gnt);
      end
    end
    check("starve_gnt_count", 64'(g_cyc.size()), 64'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < g_cyc.size()) begin
        check($sformatf("starve_gnt%0d_is_if", k), 64'(g_isif[k]), 64'((k % 5) == 4));
        check($sformatf("starve_gnt%0d_cycle", k), 64'(g_cyc[k]), 64'(1 + 4 * k));
      end
    end
    idle_inputs();
    repeat (6) tick();
    check("starve_back_idle", 64'(ctl_a), 64'h0);

    // async reset in the middle of a load's WAIT
    bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h3000;
    tick();
    check("rst_load_gnt", 64'(ctl_a), 64'(6'b011000));
    bus_a.d_req = 1'b0;
    tick();
    #3 reset = 1'b1;
    #1;
    check("rst_ctl", 64'(ctl_a), 64'h0);
    check("rst_mem_addr", 64'(bus_a.mem_addr), 64'h0);
    check("rst_mem_wdata", bus_a.mem_wdata, 64'h0);
    check("rst_if_rdata", 64'(bus_a.if_rdata), 64'h0);
    check("rst_d_rdata", bus_a.d_rdata, 64'h0);
    @(posedge clk);
    #4 reset = 1'b0;
    tick();
    rv_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (ctl_a != 6'b0) rv_seen++;
      tick();
    end
    check("rst_no_stale_activity", 64'(rv_seen), 64'h0);

    // next load after reset completes normally
    bus_a.d_req = 1'b1; bus_a.d_we = 1'b0; bus_a.d_addr = 32'h40;
    rv_cyc = -1; gnt_cyc = -1; rv_data = '0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) bus_a.d_req = 1'b0;
      if (bus_a.d_gnt && gnt_cyc < 0) gnt_cyc = c;
      if (bus_a.d_rvalid && rv_cyc < 0) begin
        rv_cyc  = c;
        rv_data = bus_a.d_rdata;
      end
    end
    check("post_rst_gnt_cycle", 64'(gnt_cyc), 64'd1);
    check("post_rst_rvalid_cycle", 64'(rv_cyc), 64'd4);
    check("post_rst_rdata", rv_data, rd_0040);

    // MEM_LAT=1 instance: load 0x80
    bus_b.d_req = 1'b1; bus_b.d_we = 1'b0; bus_b.d_addr = 32'h80;
    check("lat1_idle", 64'(ctl_b), 64'h0);
    tick();
    bus_b.d_req = 1'b0;
    check("lat1_access", 64'(ctl_b), 64'(6'b011000));
    check("lat1_mem_addr", 64'(bus_b.mem_addr), 64'h80);
    tick();
    check("lat1_wait", 64'(ctl_b), 64'h0);
    tick();
    check("lat1_resp", 64'(ctl_b), 64'(6'b000001));
    check("lat1_rdata", bus_b.d_rdata, rd_0080);
    tick();
    check("lat1_back_idle", 64'(ctl_b), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
